cmd_issuer: RTL and testbench



---
 rtl/cmd_issuer_pkg.sv | 27 ++
 rtl/cmd_issuer_timer.sv | 31 +++
 rtl/cmd_issuer.sv | 144 ++++++++++++++
 tb/tb_cmd_issuer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_issuer_pkg.sv
// Shared types for the select/data command issuer: sink selector codes,
// FSM state encoding and the raw-selector normalisation helper.
package cmd_issuer_pkg;

  typedef enum logic [1:0] {
    SEL_FOO     = 2'b00,
    SEL_BAR     = 2'b01,
    SEL_DEFAULT = 2'b10
  } sel_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    HALT
  } state_e;

  // The unused code 2'b11 folds onto the default branch of the sink.
  function automatic sel_e map_sel(input logic [1:0] raw);
    case (raw)
      2'b00:   return SEL_FOO;
      2'b01:   return SEL_BAR;
      default: return SEL_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/cmd_issuer_timer.sv
// Ack wait timer for cmd_issuer; only built when CMD_ISSUER_TIMEOUT_EN is defined.
// expired flags the TIMEOUT-th consecutive run cycle, so the FSM leaves on that edge.
module cmd_issuer_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + W'(1);
    end
  end

  // count holds the cycles already waited; the current cycle makes it TIMEOUT.
  assign expired = run && (count == LAST);

endmodule

// File: rtl/cmd_issuer.sv
// Initiator for the select/data register-load sink: one command in flight, held until ack.
// Optional ack timeout with sticky err and HALT state: define CMD_ISSUER_TIMEOUT_EN.
module cmd_issuer
  import cmd_issuer_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic [DATA_W-1:0] req_data,
  output logic [1:0]        x,
  output logic [DATA_W-1:0] z,
  output logic              stb,
  input  logic              ack,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  cnt
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("cmd_issuer: TIMEOUT must be >= 1");
  end

  state_e            state, state_nxt;
  logic              ready_nxt, stb_nxt, done_nxt;
  logic [1:0]        x_nxt;
  logic [DATA_W-1:0] z_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              accept;
  logic              timeout_hit;

  assign accept = (state == IDLE) && req_ready && req_valid;

`ifdef CMD_ISSUER_TIMEOUT_EN
  logic err_q, err_nxt;
  logic run;

  assign run = (state == WAIT_ACK) && !ack;

  cmd_issuer_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .run    (run),
    .expired(timeout_hit)
  );

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // NOTE: every always_comb target gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    ready_nxt = req_ready;
    stb_nxt   = stb;
    x_nxt     = x;
    z_nxt     = z;
    done_nxt  = 1'b0;
    cnt_nxt   = cnt;
`ifdef CMD_ISSUER_TIMEOUT_EN
    err_nxt   = err_q;
`endif
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (accept) begin
          x_nxt     = map_sel(req_sel);
          z_nxt     = req_data;
          stb_nxt   = 1'b1;
          ready_nxt = 1'b0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // ack is deliberately ignored here; the sink sees stb for a full cycle first.
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack) begin
          stb_nxt   = 1'b0;
          done_nxt  = 1'b1;
          cnt_nxt   = cnt + CNT_W'(1);
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          stb_nxt   = 1'b0;
`ifdef CMD_ISSUER_TIMEOUT_EN
          err_nxt   = 1'b1;
`endif
          state_nxt = HALT;
        end
      end
      HALT: begin
        ready_nxt = 1'b0;
        stb_nxt   = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      stb       <= 1'b0;
      x         <= SEL_DEFAULT;
      z         <= '0;
      done      <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      req_ready <= ready_nxt;
      stb       <= stb_nxt;
      x         <= x_nxt;
      z         <= z_nxt;
      done      <= done_nxt;
      cnt       <= cnt_nxt;
    end
  end

`ifdef CMD_ISSUER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_cmd_issuer.sv
// Self-checking bench for cmd_issuer: fixed vector table, directed corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_cmd_issuer;
  import cmd_issuer_pkg::*;

  localparam int DATA_W  = 8;
  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 4;
`ifdef CMD_ISSUER_TIMEOUT_EN
  localparam int STALL = 4;
`else
  localparam int STALL = 10;
`endif

  logic              clk = 1'b0;
  logic              rst, req_valid, req_ready;
  logic [1:0]        req_sel, x;
  logic [DATA_W-1:0] req_data, z;
  logic              stb, ack, done, err;
  logic [CNT_W-1:0]  cnt;

  always #5 clk = ~clk;

  cmd_issuer #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_sel  (req_sel),
    .req_data (req_data),
    .x        (x),
    .z        (z),
    .stb      (stb),
    .ack      (ack),
    .done     (done),
    .err      (err),
    .cnt      (cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit         m_busy, m_fresh, m_ready, m_done, m_err, m_halt, m_acc;
  logic [1:0] m_x;
  logic [7:0] m_z;
  int         m_acked, m_waited;

  task automatic model_step();
    m_acc  = 0;
    m_done = 0;
    if (rst) begin
      m_busy = 0; m_fresh = 0; m_ready = 0; m_err = 0; m_halt = 0;
      m_x = 2'd2; m_z = '0; m_acked = 0; m_waited = 0;
    end else if (m_halt) begin
      m_ready = 0;
    end else if (m_busy) begin
      if (m_fresh) begin
        m_fresh = 0;
      end else if (ack) begin
        m_busy = 0; m_done = 1; m_acked++; m_ready = 1;
      end else begin
        m_waited++;
`ifdef CMD_ISSUER_TIMEOUT_EN
        if (m_waited == TIMEOUT) begin
          m_busy = 0; m_err = 1; m_halt = 1;
        end
`endif
      end
    end else if (m_ready && req_valid) begin
      m_busy = 1; m_fresh = 1; m_ready = 0; m_waited = 0; m_acc = 1;
      m_x = (req_sel == 2'd3) ? 2'd2 : req_sel;
      m_z = req_data;
    end else begin
      m_ready = 1;
    end
  endtask

  function automatic logic [15:0] pk(input logic r, input logic s, input logic [1:0] xx,
                                     input logic [7:0] zz, input logic d, input logic e,
                                     input logic [1:0] c);
    return {r, s, xx, zz, d, e, c};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {req_ready, stb, x, z, done, err, cnt};
  endfunction

  function automatic logic [15:0] model_vec();
    return pk(m_ready, m_busy, m_x, m_z, m_done, m_err, 2'(m_acked % (1 << CNT_W)));
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [1:0] s,
                       input logic [7:0] d, input logic a);
    rst = r; req_valid = v; req_sel = s; req_data = d; ack = a;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cmp_model(input string name);
    check(name, dut_vec(), model_vec());
  endtask

  // Issue n commands (sel = index mod 4, data = index+1) with ack held high.
  task automatic run_burst(input int n, input string tag);
    int  idx = 0, t = 0, last_done = -1, rises = 0, dones = 0;
    bit  prev_stb = 0;
    while ((idx < n || m_busy) && t < 20 * n) begin
      if (idx < n) cycle(0, 1, 2'(idx), 8'(idx + 1), 1);
      else         cycle(0, 0, 2'd0, 8'd0, 1);
      t++;
      cmp_model({tag, "_model"});
      if (m_acc) idx++;
      if (stb && !prev_stb) begin
        check({tag, "_x"}, 32'(x), (rises % 4 == 3) ? 32'd2 : 32'(rises % 4));
        rises++;
      end
      prev_stb = stb;
      if (done) begin
        if (last_done >= 0) check({tag, "_period"}, 32'(t - last_done), 32'd3);
        last_done = t;
        dones++;
      end
    end
    check({tag, "_accepted"}, 32'(idx), 32'(n));
    check({tag, "_dones"}, 32'(dones), 32'(n));
  endtask

  typedef struct {
    logic        r, v;
    logic [1:0]  s;
    logic [7:0]  d;
    logic        a;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[13];

  task automatic set_row(input int i, input logic r, input logic v, input logic [1:0] s,
                         input logic [7:0] d, input logic a, input logic [15:0] e);
    tbl[i].r = r; tbl[i].v = v; tbl[i].s = s; tbl[i].d = d; tbl[i].a = a; tbl[i].exp = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; req_valid = 0; req_sel = 0; req_data = 0; ack = 0;

    //           r  v  sel    data   a   expected {ready,stb,x,z,done,err,cnt}
    set_row(0,  1, 0, 2'd0, 8'h00, 0, pk(0, 0, 2'd2, 8'h00, 0, 0, 2'd0));
    set_row(1,  0, 0, 2'd0, 8'h00, 0, pk(1, 0, 2'd2, 8'h00, 0, 0, 2'd0));
    set_row(2,  0, 1, 2'd0, 8'hA5, 0, pk(0, 1, 2'd0, 8'hA5, 0, 0, 2'd0));
    set_row(3,  0, 0, 2'd0, 8'h00, 0, pk(0, 1, 2'd0, 8'hA5, 0, 0, 2'd0));
    set_row(4,  0, 0, 2'd0, 8'h00, 1, pk(1, 0, 2'd0, 8'hA5, 1, 0, 2'd1));
    set_row(5,  0, 1, 2'd3, 8'h3C, 0, pk(0, 1, 2'd2, 8'h3C, 0, 0, 2'd1));
    set_row(6,  0, 0, 2'd0, 8'h00, 1, pk(0, 1, 2'd2, 8'h3C, 0, 0, 2'd1));
    set_row(7,  0, 0, 2'd0, 8'h00, 0, pk(0, 1, 2'd2, 8'h3C, 0, 0, 2'd1));
    set_row(8,  0, 0, 2'd0, 8'h00, 1, pk(1, 0, 2'd2, 8'h3C, 1, 0, 2'd2));
    set_row(9,  1, 1, 2'd1, 8'h77, 0, pk(0, 0, 2'd2, 8'h00, 0, 0, 2'd0));
    set_row(10, 0, 1, 2'd1, 8'h77, 0, pk(1, 0, 2'd2, 8'h00, 0, 0, 2'd0));
    set_row(11, 0, 1, 2'd1, 8'h77, 0, pk(0, 1, 2'd1, 8'h77, 0, 0, 2'd0));
    set_row(12, 1, 0, 2'd0, 8'h00, 1, pk(0, 0, 2'd2, 8'h00, 0, 0, 2'd0));

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].a);
      check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
    end

    // Back-to-back FOO, BAR, DEFAULT, 11 with ack held; 4 completions wrap cnt to 0.
    cycle(0, 0, 2'd0, 8'd0, 1);
    run_burst(4, "b2b");
    check("b2b_cnt", 32'(cnt), 32'd0);

    // Stability: ack withheld while the upstream bus keeps changing.
    cycle(1, 0, 2'd0, 8'd0, 0);
    cycle(0, 0, 2'd0, 8'd0, 0);
    cycle(0, 1, 2'd1, 8'h5A, 0);
    for (int k = 0; k < STALL; k++) begin
      cycle(0, 1, 2'($urandom), 8'($urandom), 0);
      check("stable_xz", {stb, x, z}, {1'b1, 2'd1, 8'h5A});
      check("stable_flags", {req_ready, done, err}, 3'b000);
    end
    cycle(0, 0, 2'd0, 8'd0, 1);
    check("stable_ack", {done, err, stb, cnt}, {1'b1, 1'b0, 1'b0, 2'd1});

    // Wrap: five completions from reset leave cnt at 1.
    cycle(1, 0, 2'd0, 8'd0, 0);
    cycle(0, 0, 2'd0, 8'd0, 0);
    run_burst(5, "wrap");
    check("wrap_cnt", 32'(cnt), 32'd1);

    // Reset in WAIT_ACK together with ack and valid: dropped, nothing counted.
    cycle(0, 1, 2'd0, 8'hC3, 0);
    cycle(0, 0, 2'd0, 8'd0, 0);
    check("mid_wait", {stb, z}, {1'b1, 8'hC3});
    cycle(1, 1, 2'd1, 8'h11, 1);
    check("mid_rst", {req_ready, stb, x, z, done, cnt}, {1'b0, 1'b0, 2'd2, 8'h00, 1'b0, 2'd0});
    cmp_model("mid_rst_model");

`ifdef CMD_ISSUER_TIMEOUT_EN
    // Timeout: ack never comes; err after TIMEOUT waited cycles, then HALT until rst.
    cycle(0, 0, 2'd0, 8'd0, 0);
    cycle(0, 1, 2'd0, 8'h42, 0);
    cycle(0, 0, 2'd0, 8'd0, 0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      cycle(0, 0, 2'd0, 8'd0, 0);
      if (k < TIMEOUT) check("to_wait", {stb, err}, 2'b10);
      else             check("to_expire", {stb, err}, 2'b01);
    end
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 2'd1, 8'h99, 1);
      check("to_halt", {req_ready, stb, err, done}, 4'b0010);
    end
    cycle(1, 0, 2'd0, 8'd0, 0);
    check("to_rst", {err, req_ready}, 2'b00);
`else
    // Without the timeout the issuer waits indefinitely.
    cycle(0, 0, 2'd0, 8'd0, 0);
    cycle(0, 1, 2'd2, 8'h24, 0);
    for (int k = 0; k < 20; k++) begin
      cycle(0, 0, 2'd0, 8'd0, 0);
      check("nto_wait", {stb, err, done}, 3'b100);
    end
    cycle(0, 0, 2'd0, 8'd0, 1);
    check("nto_ack", {done, err, stb}, 3'b100);
`endif

    // Randomized traffic against the model.
    cycle(1, 0, 2'd0, 8'd0, 0);
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 6), 2'($urandom),
            8'($urandom), ($urandom_range(0, 9) < 4));
      cmp_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
